// File: rtl/onehot_rr_arbiter.sv
// Four-requester round-robin arbiter with one-hot Moore FSM, hold-time limit,
// and a fixed one-cycle release turnaround between owners.
//
// state | meaning
// IDLE  | no owner; evaluate REQ from the round-robin pointer
// G0-G3 | requester k owns the resource; hold counter running
// REL   | turnaround cycle with all grants low; always returns to IDLE
module onehot_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    input  logic       DONE,
    output logic [3:0] GNT,
    output logic       BUSY,
    output logic       TIMEOUT,
    output logic [5:0] STATE
);

    localparam logic [5:0] S_IDLE = 6'b000001;
    localparam logic [5:0] S_G0   = 6'b000010;
    localparam logic [5:0] S_G1   = 6'b000100;
    localparam logic [5:0] S_G2   = 6'b001000;
    localparam logic [5:0] S_G3   = 6'b010000;
    localparam logic [5:0] S_REL  = 6'b100000;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [5:0] state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    logic       state_legal;
    logic [1:0] pick_idx;
    logic [1:0] own_idx;
    logic       own_req;
    logic       hold_expired;

    assign state_legal  = $onehot(state_q);
    assign hold_expired = (hold_q == HOLD_LAST);

    // First requester at or after the pointer; the descending loop lets the nearest one win.
    always_comb begin
        pick_idx = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (REQ[ptr_q + 2'(i)]) begin
                pick_idx = ptr_q + 2'(i);
            end
        end
    end

    // Index of the current owner, and whether it is still requesting.
    always_comb begin
        own_idx = 2'd0;
        unique case (1'b1)
            state_q[2]: own_idx = 2'd1;
            state_q[3]: own_idx = 2'd2;
            state_q[4]: own_idx = 2'd3;
            default:    own_idx = 2'd0;
        endcase
        own_req = REQ[own_idx];
    end

    // State register, pointer, hold counter and registered timeout flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ptr_q     <= 2'd0;
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic; anything that is not exactly one-hot recovers to IDLE with ptr kept.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        if (!state_legal) begin
            state_d = S_IDLE;
            hold_d  = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (REQ != 4'b0000) begin
                        state_d = 6'(S_G0 << pick_idx);
                        hold_d  = 8'd0;
                    end
                end
                S_G0, S_G1, S_G2, S_G3: begin
                    if (DONE || !own_req || hold_expired) begin
                        state_d   = S_REL;
                        ptr_d     = own_idx + 2'd1;
                        hold_d    = 8'd0;
                        // Expiry only counts as a timeout when nothing else ended the grant.
                        timeout_d = hold_expired && !DONE && own_req;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                S_REL: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from the registered state; grants are suppressed in an illegal state.
    always_comb begin
        GNT     = state_legal ? state_q[4:1] : 4'b0000;
        BUSY    = ~state_q[0];
        TIMEOUT = timeout_q;
        STATE   = state_q;
    end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Testbench for onehot_rr_arbiter: fixed vector table, directed corner sequences,
// and randomized traffic compared against a cycle-level behavioural model.
module tb_onehot_rr_arbiter;

    localparam int MAX_HOLD = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] REQ = 4'b0000;
    logic       DONE = 1'b0;
    logic [3:0] GNT;
    logic       BUSY;
    logic       TIMEOUT;
    logic [5:0] STATE;

    int total = 0;
    int bad = 0;

    onehot_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .DONE(DONE),
        .GNT(GNT), .BUSY(BUSY), .TIMEOUT(TIMEOUT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: owner (-1 = nobody), release flag, pointer, held cycles, timeout flag.
    int m_owner = -1;
    bit m_rel = 1'b0;
    int m_ptr = 0;
    int m_held = 0;
    bit m_to = 1'b0;

    task automatic model_step();
        if (RST) begin
            m_owner = -1; m_rel = 1'b0; m_ptr = 0; m_held = 0; m_to = 1'b0;
        end else if (m_rel) begin
            m_rel = 1'b0; m_to = 1'b0;
        end else if (m_owner >= 0) begin
            bit still_wants;
            bit used_all;
            still_wants = REQ[m_owner];
            used_all = (m_held + 1 >= MAX_HOLD);
            m_to = 1'b0;
            if (DONE || !still_wants || used_all) begin
                m_to = used_all && !DONE && still_wants;
                m_ptr = (m_owner + 1) % 4;
                m_owner = -1;
                m_rel = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            m_to = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (m_owner < 0 && REQ[(m_ptr + i) % 4]) begin
                    m_owner = (m_ptr + i) % 4;
                    m_held = 0;
                end
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int e_gnt;
        int e_state;
        e_gnt = (m_owner >= 0) ? (1 << m_owner) : 0;
        e_state = m_rel ? 32 : ((m_owner >= 0) ? (2 << m_owner) : 1);
        check("model_gnt", int'(GNT), e_gnt);
        check("model_state", int'(STATE), e_state);
        check("model_busy", int'(BUSY), int'(m_rel || m_owner >= 0));
        check("model_timeout", int'(TIMEOUT), int'(m_to));
        check("gnt_onehot0", int'($countones(GNT) <= 1), 1);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        RST = 1'b1; REQ = 4'b0000; DONE = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    typedef struct {
        bit       rst;
        bit [3:0] req;
        bit       done;
        bit [3:0] exp_gnt;
        bit       exp_to;
        bit [5:0] exp_state;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int n_gnt;
        // Round-robin with REQ=1111 and DONE pulsed on each grant; DONE ignored in REL/IDLE.
        vecs.push_back('{1, 4'hF, 0, 4'b0000, 0, 6'b000001});
        vecs.push_back('{0, 4'hF, 0, 4'b0001, 0, 6'b000010});
        vecs.push_back('{0, 4'hF, 1, 4'b0000, 0, 6'b100000});
        vecs.push_back('{0, 4'hF, 0, 4'b0000, 0, 6'b000001});
        vecs.push_back('{0, 4'hF, 0, 4'b0010, 0, 6'b000100});
        vecs.push_back('{0, 4'hF, 1, 4'b0000, 0, 6'b100000});
        vecs.push_back('{0, 4'hF, 0, 4'b0000, 0, 6'b000001});
        vecs.push_back('{0, 4'hF, 0, 4'b0100, 0, 6'b001000});
        vecs.push_back('{0, 4'hF, 1, 4'b0000, 0, 6'b100000});
        vecs.push_back('{0, 4'hF, 0, 4'b0000, 0, 6'b000001});
        vecs.push_back('{0, 4'hF, 0, 4'b1000, 0, 6'b010000});
        vecs.push_back('{0, 4'hF, 1, 4'b0000, 0, 6'b100000});
        vecs.push_back('{0, 4'hF, 1, 4'b0000, 0, 6'b000001});
        vecs.push_back('{0, 4'hF, 0, 4'b0001, 0, 6'b000010});
        vecs.push_back('{0, 4'hF, 1, 4'b0000, 0, 6'b100000});
        vecs.push_back('{0, 4'h0, 1, 4'b0000, 0, 6'b000001});
        vecs.push_back('{0, 4'h0, 1, 4'b0000, 0, 6'b000001});
        // Pointer now 1: REQ=1001 must pick requester 3 before wrapping to 0.
        vecs.push_back('{0, 4'h9, 0, 4'b1000, 0, 6'b010000});

        #2;
        foreach (vecs[i]) begin
            RST = vecs[i].rst; REQ = vecs[i].req; DONE = vecs[i].done;
            tick();
            check("vec_gnt", int'(GNT), int'(vecs[i].exp_gnt));
            check("vec_state", int'(STATE), int'(vecs[i].exp_state));
            check("vec_timeout", int'(TIMEOUT), int'(vecs[i].exp_to));
        end

        // Reset in the middle of a G2 grant, then REQ=1111 restarts at requester 0.
        do_reset();
        REQ = 4'b0100;
        tick();
        check("reach_g2", int'(STATE), 8);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst_state", int'(STATE), 1);
        check("rst_gnt", int'(GNT), 0);
        check("rst_timeout", int'(TIMEOUT), 0);
        REQ = 4'b1111;
        tick();
        check("post_rst_gnt", int'(GNT), 1);

        // Expiry: a lone requester holds for exactly MAX_HOLD cycles, then REL with TIMEOUT.
        do_reset();
        REQ = 4'b0001;
        n_gnt = 0;
        for (int i = 0; i < 3 * MAX_HOLD; i++) begin
            tick();
            if (GNT[0]) n_gnt++;
            else if (n_gnt > 0) break;
        end
        check("hold_cycles", n_gnt, MAX_HOLD);
        check("expiry_rel", int'(STATE), 32);
        check("expiry_timeout", int'(TIMEOUT), 1);
        tick();
        check("expiry_idle", int'(STATE), 1);
        check("expiry_to_clear", int'(TIMEOUT), 0);
        tick();
        check("expiry_regrant", int'(GNT), 1);

        // Withdrawal from G1 moves the pointer to 2; REQ=0101 then grants requester 2.
        do_reset();
        REQ = 4'b0010;
        tick();
        check("wd_g1", int'(GNT), 2);
        REQ = 4'b0101;
        tick();
        check("wd_rel", int'(STATE), 32);
        check("wd_timeout", int'(TIMEOUT), 0);
        tick();
        tick();
        check("wd_next", int'(GNT), 4);

        // DONE on the expiry cycle is a normal exit.
        do_reset();
        REQ = 4'b0001;
        tick();
        for (int i = 1; i < MAX_HOLD; i++) tick();
        check("late_still_g0", int'(GNT), 1);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        check("done_exp_rel", int'(STATE), 32);
        check("done_exp_timeout", int'(TIMEOUT), 0);

        // Illegal two-hot state: no grant while it lasts, recovery to IDLE.
        do_reset();
        REQ = 4'b0000;
        @(negedge CLK);
        force dut.state_q = 6'b000110;
        #1;
        check("illegal_state", int'(STATE), 6);
        check("illegal_gnt", int'(GNT), 0);
        release dut.state_q;
        tick();
        check("illegal_recover", int'(STATE), 1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            RST  = ($urandom_range(0, 299) == 0);
            REQ  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0 && m_owner >= 0) REQ[m_owner] = 1'b1;
            DONE = ($urandom_range(0, 11) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
